// File: rtl/evp_pkg.sv
//------------------------------------------------------------------------------
// Module  : evp_pkg
// Brief   : Shared widths, slot geometry and error-bit indices for the EVP
//           operand server and the EVP FSM.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package evp_pkg;

    localparam int c_word_size  = 16;
    localparam int c_s_addr_w   = 7;
    localparam int c_n_addr_w   = 3;
    localparam int c_n_data_w   = 5;

    localparam int c_n_poly     = 8;
    localparam int c_n_coeff    = 11;
    localparam int c_s_depth    = c_n_poly * c_n_coeff;

    localparam int c_err_w         = 3;
    localparam int c_err_addr      = 0;
    localparam int c_err_underflow = 1;
    localparam int c_err_overflow  = 2;

    typedef logic [c_err_w-1:0] err_t;

endpackage

`default_nettype wire

// File: rtl/evp_circ_buf.sv
//------------------------------------------------------------------------------
// Module  : evp_circ_buf
// Brief   : Circular data FIFO with registered pop data, occupancy count and
//           single-cycle overflow/underflow indications.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module evp_circ_buf #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 1024,
    parameter bit BYPASS = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_value,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_pop_vld,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int                  c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]    c_depth = (c_ptr_w + 1)'(DEPTH);
    localparam logic [c_ptr_w-1:0]  c_ptr_one = c_ptr_w'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic [WIDTH-1:0]   r_pop_data;
    logic               r_pop_vld;

    logic w_empty;
    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;
    logic w_fwd;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);
    // A pop on a full buffer frees the slot the simultaneous push needs.
    assign w_push_ok = i_push && (!w_full || i_pop);
    assign w_pop_ok  = i_pop && (!w_empty || (BYPASS && i_push));
    assign w_fwd     = w_empty && w_pop_ok;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pop_data <= '0;
            r_pop_vld  <= 1'b0;
        end else begin
            r_pop_vld <= w_pop_ok;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rd_ptr   <= r_rd_ptr + c_ptr_one;
                r_pop_data <= w_fwd ? i_push_value : r_mem[r_rd_ptr];
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_pop_data  = r_pop_data;
    assign o_pop_vld   = r_pop_vld;
    assign o_count     = r_count;
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_overflow  = i_push && !w_push_ok;
    assign o_underflow = i_pop && !w_pop_ok;

endmodule

`default_nettype wire

// File: rtl/evp_operand_server.sv
//------------------------------------------------------------------------------
// Module  : evp_operand_server
// Brief   : Coefficient (S) and degree (N) stores plus data FIFO feeding the
//           EVP datapath. Define EVP_OPSRV_WR_BYPASS_EN to forward same-cycle
//           write data to colliding reads / pops on an empty FIFO.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module evp_operand_server
    import evp_pkg::*;
#(
    parameter int word_size   = c_word_size,
    parameter int buffer_size = 1024,
    parameter int n_poly      = c_n_poly,
    parameter int n_coeff     = c_n_coeff
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en_S,
    input  logic [c_s_addr_w-1:0]         wr_addr_S,
    input  logic [word_size-1:0]          wr_data_S,
    input  logic                          wr_en_N,
    input  logic [c_n_addr_w-1:0]         wr_addr_N,
    input  logic [c_n_data_w-1:0]         wr_data_N,
    input  logic                          push_data,
    input  logic [word_size-1:0]          push_value,
    input  logic                          en_rd_S,
    input  logic [c_s_addr_w-1:0]         rd_addr_S,
    output logic [word_size-1:0]          c_i,
    output logic                          vld_S,
    input  logic                          en_rd_N,
    input  logic [c_n_addr_w-1:0]         rd_addr_N,
    output logic [c_n_data_w-1:0]         N,
    output logic                          vld_N,
    input  logic                          en_rd_data,
    output logic [word_size-1:0]          x,
    output logic                          vld_data,
    output logic [$clog2(buffer_size):0]  data_count,
    output logic                          full,
    output logic                          empty,
    output logic [c_err_w-1:0]            err
);

`ifdef EVP_OPSRV_WR_BYPASS_EN
    localparam bit c_bypass = 1'b1;
`else
    localparam bit c_bypass = 1'b0;
`endif

    localparam int c_s_words = n_poly * n_coeff;

    logic [word_size-1:0]  r_s_mem [c_s_words];
    logic [c_n_data_w-1:0] r_n_mem [n_poly];
    logic [word_size-1:0]  r_c_i;
    logic                  r_vld_s;
    logic [c_n_data_w-1:0] r_n;
    logic                  r_vld_n;
    err_t                  r_err;

    logic w_s_wr_ok;
    logic w_s_rd_ok;
    logic w_n_wr_ok;
    logic w_n_rd_ok;
    logic w_addr_err;
    logic w_overflow;
    logic w_underflow;

    assign w_s_wr_ok = (int'(wr_addr_S) < c_s_words);
    assign w_s_rd_ok = (int'(rd_addr_S) < c_s_words);
    assign w_n_wr_ok = (int'(wr_addr_N) < n_poly);
    assign w_n_rd_ok = (int'(rd_addr_N) < n_poly);

    assign w_addr_err = (wr_en_S && !w_s_wr_ok) || (en_rd_S && !w_s_rd_ok) ||
                        (wr_en_N && !w_n_wr_ok) || (en_rd_N && !w_n_rd_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_s_words; i++) begin
                r_s_mem[i] <= '0;
            end
        end else if (wr_en_S && w_s_wr_ok) begin
            r_s_mem[wr_addr_S] <= wr_data_S;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < n_poly; i++) begin
                r_n_mem[i] <= '0;
            end
        end else if (wr_en_N && w_n_wr_ok) begin
            r_n_mem[wr_addr_N] <= wr_data_N;
        end
    end

    // Reads sample the store before this edge's write lands, so a colliding
    // read returns the old word unless forwarding is built in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c_i   <= '0;
            r_vld_s <= 1'b0;
            r_n     <= '0;
            r_vld_n <= 1'b0;
        end else begin
            r_vld_s <= en_rd_S;
            r_vld_n <= en_rd_N;
            if (en_rd_S) begin
                if (!w_s_rd_ok) begin
                    r_c_i <= '0;
                end else if (c_bypass && wr_en_S && (wr_addr_S == rd_addr_S)) begin
                    r_c_i <= wr_data_S;
                end else begin
                    r_c_i <= r_s_mem[rd_addr_S];
                end
            end
            if (en_rd_N) begin
                if (!w_n_rd_ok) begin
                    r_n <= '0;
                end else if (c_bypass && wr_en_N && (wr_addr_N == rd_addr_N)) begin
                    r_n <= wr_data_N;
                end else begin
                    r_n <= r_n_mem[rd_addr_N];
                end
            end
        end
    end

    evp_circ_buf #(
        .WIDTH  (word_size),
        .DEPTH  (buffer_size),
        .BYPASS (c_bypass)
    ) u_circ_buf (
        .clk          (clk),
        .rst          (rst),
        .i_push       (push_data),
        .i_push_value (push_value),
        .i_pop        (en_rd_data),
        .o_pop_data   (x),
        .o_pop_vld    (vld_data),
        .o_count      (data_count),
        .o_full       (full),
        .o_empty      (empty),
        .o_overflow   (w_overflow),
        .o_underflow  (w_underflow)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= '0;
        end else begin
            r_err[c_err_addr]      <= r_err[c_err_addr]      | w_addr_err;
            r_err[c_err_underflow] <= r_err[c_err_underflow] | w_underflow;
            r_err[c_err_overflow]  <= r_err[c_err_overflow]  | w_overflow;
        end
    end

    assign c_i   = r_c_i;
    assign vld_S = r_vld_s;
    assign N     = r_n;
    assign vld_N = r_vld_n;
    assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_evp_operand_server.sv
//------------------------------------------------------------------------------
// Module  : tb_evp_operand_server
// Brief   : Directed plus randomized checks of evp_operand_server against a
//           store/queue reference model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_evp_operand_server;

    localparam int WS    = 16;
    localparam int DEPTH = 1024;
    localparam int SD    = 88;
`ifdef EVP_OPSRV_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en_S, wr_en_N, push_data, en_rd_S, en_rd_N, en_rd_data;
    logic [6:0]    wr_addr_S, rd_addr_S;
    logic [2:0]    wr_addr_N, rd_addr_N;
    logic [WS-1:0] wr_data_S, push_value;
    logic [4:0]    wr_data_N;
    logic [WS-1:0] c_i, x;
    logic [4:0]    N;
    logic          vld_S, vld_N, vld_data, full, empty;
    logic [10:0]   data_count;
    logic [2:0]    err;

    always #5 clk = ~clk;

    evp_operand_server dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en_S    (wr_en_S),
        .wr_addr_S  (wr_addr_S),
        .wr_data_S  (wr_data_S),
        .wr_en_N    (wr_en_N),
        .wr_addr_N  (wr_addr_N),
        .wr_data_N  (wr_data_N),
        .push_data  (push_data),
        .push_value (push_value),
        .en_rd_S    (en_rd_S),
        .rd_addr_S  (rd_addr_S),
        .c_i        (c_i),
        .vld_S      (vld_S),
        .en_rd_N    (en_rd_N),
        .rd_addr_N  (rd_addr_N),
        .N          (N),
        .vld_N      (vld_N),
        .en_rd_data (en_rd_data),
        .x          (x),
        .vld_data   (vld_data),
        .data_count (data_count),
        .full       (full),
        .empty      (empty),
        .err        (err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: plain arrays for the stores, a queue for the FIFO.
    logic [WS-1:0] m_s [SD];
    logic [4:0]    m_n [8];
    logic [WS-1:0] m_q [$];
    logic [WS-1:0] e_c_i, e_x;
    logic [4:0]    e_n;
    logic          e_vs, e_vn, e_vd;
    logic [2:0]    e_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SD; i++) m_s[i] = '0;
        for (int i = 0; i < 8; i++) m_n[i] = '0;
        m_q.delete();
        e_c_i = '0; e_x = '0; e_n = '0;
        e_vs = 1'b0; e_vn = 1'b0; e_vd = 1'b0;
        e_err = '0;
    endtask

    task automatic idle();
        wr_en_S = 1'b0; wr_en_N = 1'b0; push_data = 1'b0;
        en_rd_S = 1'b0; en_rd_N = 1'b0; en_rd_data = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".c_i"},   32'(c_i),        32'(e_c_i));
        check({tag, ".vld_S"}, 32'(vld_S),      32'(e_vs));
        check({tag, ".N"},     32'(N),          32'(e_n));
        check({tag, ".vld_N"}, 32'(vld_N),      32'(e_vn));
        check({tag, ".x"},     32'(x),          32'(e_x));
        check({tag, ".vld_d"}, 32'(vld_data),   32'(e_vd));
        check({tag, ".count"}, 32'(data_count), 32'(m_q.size()));
        check({tag, ".full"},  32'(full),       32'(m_q.size() == DEPTH));
        check({tag, ".empty"}, 32'(empty),      32'(m_q.size() == 0));
        check({tag, ".err"},   32'(err),        32'(e_err));
    endtask

    // Predict the effect of the currently driven inputs, clock once, compare.
    task automatic cycle(input string tag);
        bit consumed;
        consumed = 1'b0;
        e_vs = en_rd_S;
        if (en_rd_S) begin
            if (int'(rd_addr_S) >= SD) begin
                e_c_i = '0;
                e_err[0] = 1'b1;
            end else if (BYP && wr_en_S && wr_addr_S == rd_addr_S) e_c_i = wr_data_S;
            else e_c_i = m_s[rd_addr_S];
        end
        e_vn = en_rd_N;
        if (en_rd_N) e_n = (BYP && wr_en_N && wr_addr_N == rd_addr_N) ? wr_data_N : m_n[rd_addr_N];
        if (wr_en_S) begin
            if (int'(wr_addr_S) < SD) m_s[wr_addr_S] = wr_data_S;
            else e_err[0] = 1'b1;
        end
        if (wr_en_N) m_n[wr_addr_N] = wr_data_N;
        e_vd = 1'b0;
        if (en_rd_data) begin
            if (m_q.size() > 0) begin
                e_x = m_q.pop_front();
                e_vd = 1'b1;
            end else if (BYP && push_data) begin
                e_x = push_value;
                e_vd = 1'b1;
                consumed = 1'b1;
            end else e_err[1] = 1'b1;
        end
        if (push_data && !consumed) begin
            if (m_q.size() < DEPTH) m_q.push_back(push_value);
            else e_err[2] = 1'b1;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    localparam logic [WS-1:0] EXP_COLL = BYP ? 16'd7 : 16'd9;

    initial begin
        rst = 1'b0;
        idle();
        wr_addr_S = '0; rd_addr_S = '0; wr_addr_N = '0; rd_addr_N = '0;
        wr_data_S = '0; wr_data_N = '0; push_value = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Coefficient and degree round trip
        for (int i = 0; i < 4; i++) begin
            idle();
            wr_en_S = 1'b1; wr_addr_S = 7'(i);
            wr_data_S = (i == 0) ? 16'd3 : (i == 1) ? 16'd4 : (i == 2) ? 16'd2 : 16'd1;
            cycle("wr_s");
        end
        idle(); wr_en_N = 1'b1; wr_addr_N = 3'd0; wr_data_N = 5'd3;
        cycle("wr_n");
        for (int i = 0; i < 4; i++) begin
            idle(); en_rd_S = 1'b1; rd_addr_S = 7'(i);
            cycle("rd_s");
        end
        check("rd_s3_lit", 32'(c_i), 32'd1);
        idle(); en_rd_N = 1'b1; rd_addr_N = 3'd0;
        cycle("rd_n");
        check("rd_n_lit", 32'(N), 32'd3);
        idle();
        cycle("rd_hold");

        // Same-address write/read collision
        idle(); wr_en_S = 1'b1; wr_addr_S = 7'd5; wr_data_S = 16'd9;
        cycle("coll_pre");
        idle(); wr_en_S = 1'b1; wr_addr_S = 7'd5; wr_data_S = 16'd7;
        en_rd_S = 1'b1; rd_addr_S = 7'd5;
        cycle("coll");
        check("coll_lit", 32'(c_i), 32'(EXP_COLL));

        // Out-of-range read
        idle(); en_rd_S = 1'b1; rd_addr_S = 7'd88;
        cycle("rd88");
        check("rd88_err", 32'(err[0]), 32'd1);

        // FIFO order and underflow
        for (int i = 0; i < 3; i++) begin
            idle(); push_data = 1'b1;
            push_value = (i == 0) ? 16'd2 : (i == 1) ? 16'd1 : 16'd4;
            cycle("push");
        end
        for (int i = 0; i < 3; i++) begin
            idle(); en_rd_data = 1'b1;
            cycle("pop");
        end
        idle(); en_rd_data = 1'b1;
        cycle("pop_empty");
        check("underflow_x", 32'(x), 32'd4);
        check("underflow_err", 32'(err[1]), 32'd1);

        // Push and pop on empty FIFO in the same cycle
        idle(); push_data = 1'b1; push_value = 16'hA5A5; en_rd_data = 1'b1;
        cycle("pushpop_empty");

        // Randomized traffic with frequent address collisions
        for (int n = 0; n < 400; n++) begin
            wr_en_S    = 1'($urandom_range(0, 1));
            wr_addr_S  = 7'($urandom_range(0, 95));
            wr_data_S  = 16'($urandom());
            en_rd_S    = 1'($urandom_range(0, 1));
            rd_addr_S  = ($urandom_range(0, 3) == 0) ? wr_addr_S : 7'($urandom_range(0, 95));
            wr_en_N    = 1'($urandom_range(0, 1));
            wr_addr_N  = 3'($urandom_range(0, 7));
            wr_data_N  = 5'($urandom());
            en_rd_N    = 1'($urandom_range(0, 1));
            rd_addr_N  = ($urandom_range(0, 3) == 0) ? wr_addr_N : 3'($urandom_range(0, 7));
            push_data  = 1'($urandom_range(0, 1));
            push_value = 16'($urandom());
            en_rd_data = 1'($urandom_range(0, 1));
            cycle("rand");
        end

        // Fill, overflow, then push+pop while full
        while (m_q.size() < DEPTH) begin
            idle(); push_data = 1'b1; push_value = 16'($urandom());
            cycle("fill");
        end
        idle(); push_data = 1'b1; push_value = 16'hDEAD;
        cycle("overflow");
        check("full_lit", 32'(full), 32'd1);
        check("ovf_err", 32'(err[2]), 32'd1);
        idle(); push_data = 1'b1; push_value = 16'hBEEF; en_rd_data = 1'b1;
        cycle("full_pushpop");
        check("full_count", 32'(data_count), 32'(DEPTH));

        // Reset in the middle of a pending read
        @(negedge clk);
        rst = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(); wr_en_S = 1'b1; wr_addr_S = 7'd0; wr_data_S = 16'd3;
        cycle("rs_wr");
        for (int i = 0; i < 3; i++) begin
            idle(); push_data = 1'b1; push_value = 16'(i + 10);
            cycle("rs_push");
        end
        idle(); en_rd_S = 1'b1; rd_addr_S = 7'd0; en_rd_N = 1'b1; en_rd_data = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        rst = 1'b1;
        idle(); en_rd_S = 1'b1; rd_addr_S = 7'd0; push_data = 1'b1; push_value = 16'h55;
        cycle("post_rst");
        check("post_rst_s0", 32'(c_i), 32'd0);
        check("post_rst_cnt", 32'(data_count), 32'd1);
        idle();
        cycle("post_rst_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/evp_operand_server.md
EVP_OPERAND_SERVER -- requirements
Module: evp_operand_server

Interface
REQ-001 SHALL have parameters: word_size, default 16, data/coefficient width; buffer_size, default 1024, data FIFO depth (power of two); n_poly, default 8, polynomial slots; n_coeff, default 11, coefficients per slot.
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 wr_en_S  in  1, wr_addr_S  in  7, wr_data_S  in  word_size  coefficient write port.
REQ-005 wr_en_N  in  1, wr_addr_N  in  3, wr_data_N  in  5  degree write port.
REQ-006 push_data  in  1, push_value  in  word_size  data FIFO write.
REQ-007 en_rd_S  in  1, rd_addr_S  in  7  -> c_i  out  word_size, vld_S  out  1.
REQ-008 en_rd_N  in  1, rd_addr_N  in  3  -> N  out  5, vld_N  out  1.
REQ-009 en_rd_data  in  1  (pop head) -> x  out  word_size, vld_data  out  1.
REQ-010 data_count  out  log2(buffer_size)+1, full  out  1, empty  out  1, err  out  3 {overflow, underflow, addr_range}.

Function
REQ-011 S store SHALL hold n_poly*n_coeff (88) words; slot k coefficient j at address k*n_coeff+j.
REQ-012 Writes SHALL commit at the rising edge where enable is high; writes with wr_addr_S>=88 SHALL be dropped and set err[0].
REQ-013 Reads SHALL have 1-cycle latency: c_i/N/x registered on the edge after enable, with matching vld_* high for exactly that one cycle.
REQ-014 Without enable, c_i, N, x SHALL hold their last value; vld_* SHALL be 0.
REQ-015 rd_addr_S>=88 SHALL return c_i=0, vld_S=1, and set err[0].
REQ-016 Same-cycle write and read of the same S or N address SHALL return the old (pre-write) value unless REQ-027 applies.
REQ-017 Data FIFO SHALL be circular: push writes at wr_ptr, pop reads at rd_ptr, pointers wrap from buffer_size-1 to 0.
REQ-018 data_count SHALL equal pushes minus pops accepted, range 0..buffer_size; full=(count==buffer_size), empty=(count==0).
REQ-019 Push while full and no pop SHALL be dropped and set err[2]; push+pop while full SHALL both proceed, count unchanged.
REQ-020 Pop while empty SHALL be ignored (x held, vld_data=0) and set err[1]; a simultaneous push on empty SHALL still be accepted.
REQ-021 err bits SHALL be sticky until reset.

Reset
REQ-022 rst low SHALL asynchronously clear: pointers, data_count, err, c_i, N, x, vld_* to 0; empty=1, full=0.
REQ-023 S and N contents SHALL also clear to 0 on reset.
REQ-024 Reset asserted mid-read SHALL suppress that read's vld_* and return to the idle state.
REQ-025 First operation SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-026 Macro EVP_OPSRV_WR_BYPASS_EN SHALL select collision behaviour.
REQ-027 Defined: same-address same-cycle S/N write+read, and push+pop on empty FIFO, SHALL forward the new write data to the output (pop on empty then accepted, no err[1]); undefined: REQ-016/REQ-020 apply.

Structure
REQ-028 Package evp_pkg SHALL hold word_size, S/N address widths, slot constants (8, 11, 88) and err bit index constants, shared with EVP FSM.
REQ-029 Sub-module evp_circ_buf SHALL implement the data FIFO (pointers, count, full/empty, overflow/underflow).

Verification
REQ-030 Write S[0..3]=3,4,2,1, N[0]=3; read S[0..3], N[0] -> c_i 3,4,2,1 and N=3, each one cycle after enable with vld high.
REQ-031 Push 2,1,4; pop x3 -> x=2,1,4, data_count 3->0, empty=1; fourth pop -> err[1]=1, x stays 4.
REQ-032 Push buffer_size values, then one more -> full=1, err[2]=1, dropped; push+pop same cycle -> count stays buffer_size.
REQ-033 Read rd_addr_S=88 -> c_i=0, vld_S=1, err[0]=1.
REQ-034 Write S[5]=7 over old 9 with same-cycle read of S[5] -> c_i=9 without macro, 7 with EVP_OPSRV_WR_BYPASS_EN.
REQ-035 Assert rst after 3 pushes and during a pending read -> count 0, empty 1, vld_* 0, S[0]=0 after release.
